ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline; consumes the 2-bit operand selects from the forwarding unit.
//  Selects forwarded operands, runs the ALU and a multi-cycle iterative multiplier, and owns the EX/MEM register.
//  Raises stall_o so the hazard logic can hold IF/ID/ID-EX while a MUL iterates or MEM is stalled.
// PARAMETERS
//  DATA_W  32  datapath width; multiplier iterates DATA_W cycles
//  REG_AW  5   register-index width
// PORTS
//  clk_i               in   1       clock, rising edge
//  rst_n_i             in   1       asynchronous active-low reset
//  idex_valid_i        in   1       ID/EX holds a real instruction
//  idex_aluop_i        in   4       operation code (ex_pkg::ALUOP_*)
//  idex_rs_data_i      in   DATA_W  Rs value read in ID
//  idex_rt_data_i      in   DATA_W  Rt value read in ID
//  idex_imm_i          in   DATA_W  sign/zero-extended immediate
//  idex_alusrc_i       in   1       1: operand B = immediate
//  idex_shamt_i        in   5       shift amount
//  idex_rd_i           in   REG_AW  destination register
//  idex_regwrite_i, idex_memread_i, idex_memwrite_i, idex_memtoreg_i  in 1 each  control bits
//  alu_data1_sel_i     in   2       Rs select: 2'b10 EX/MEM, 2'b01 MEM/WB, else ID/EX
//  alu_data2_sel_i     in   2       Rt select, same encoding
//  exmem_fwd_data_i    in   DATA_W  EX/MEM ALU result for forwarding
//  memwb_fwd_data_i    in   DATA_W  MEM/WB write-back data for forwarding
//  mem_stall_i         in   1       MEM stage cannot accept; freeze EX/MEM
//  flush_i             in   1       kill the instruction in EX
//  stall_o             out  1       hold upstream stages
//  exmem_valid_o       out  1       EX/MEM holds a real instruction
//  exmem_alu_result_o  out  DATA_W  ALU/MUL result
//  exmem_store_data_o  out  DATA_W  forwarded Rt (store data)
//  exmem_rd_o          out  REG_AW  destination register
//  exmem_regwrite_o, exmem_memread_o, exmem_memwrite_o, exmem_memtoreg_o  out 1 each
//  ovf_trap_o          out  1       registered signed-overflow trap (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n_i=0): all outputs 0, multiplier FSM IDLE, counter 0; stall_o=0.
//  - Operand A = fwd(sel1, rs); store data = fwd(sel2, rt); operand B = alusrc ? imm : store data. Sel 2'b11 = no forward.
//  - ALU ops: ADD SUB AND OR XOR NOR SLT(signed) SLL SRL SRA LUI; add/sub wrap mod 2^DATA_W. MUL = low DATA_W bits of product.
//  - Single-cycle ops: result captured into EX/MEM on the next edge (latency 1).
//  - Multiplier FSM IDLE/BUSY/DONE:
//     IDLE: valid MUL in EX and !flush -> latch forwarded A,B, count=0, go BUSY; stall_o=1 this cycle.
//     BUSY: one shift-add step per cycle; after step DATA_W-1 go DONE; stall_o=1.
//     DONE: stall_o=mem_stall_i; product written to EX/MEM when !mem_stall_i, then IDLE.
//     MUL issued in cycle T: stall_o high T..T+DATA_W, result in EX/MEM from T+DATA_W+2.
//  - While stall_o from the multiplier: EX/MEM receives a bubble each cycle (older ops drain).
//  - stall_o = mem_stall_i | (FSM in IDLE-starting-MUL or BUSY).
//  - mem_stall_i=1: EX/MEM and FSM state held (BUSY still counts only if EX/MEM not needed; DONE holds).
//  - flush_i=1 (priority over mem_stall_i): EX/MEM <= bubble, FSM -> IDLE, pending MUL discarded.
//  - Bubble: valid, regwrite, memread, memwrite, memtoreg, ovf_trap = 0; data/rd = 0.
//  - idex_valid_i=0: bubble into EX/MEM, no MUL started.
// CONFIGURATION
//  EX_OVF_TRAP_EN defined: signed overflow on ADD/SUB makes EX/MEM a bubble (no reg write) and sets ovf_trap_o for that
//   one registered cycle. Undefined: results wrap, ovf_trap_o tied 0.
// STRUCTURE
//  ex_pkg: ALUOP_* codes, FWD_NONE=2'b00/FWD_MEMWB=2'b01/FWD_EXMEM=2'b10, mul FSM state enum.
//  Sub-module seq_multiplier (start, operands, busy, done, product); ALU and forwarding muxes inline.
// TESTING
//  Fwd: sel1=10, exmem_fwd=5, rs=9, ADD imm 3 -> exmem_alu_result_o=8; sel1=01, memwb_fwd=7 -> 10.
//  Both sels=10 and 01 priority from upstream honoured; sel=11, rs=4, rt=6, SUB -> 0xFFFFFFFE.
//  MUL A=0x0001_0003, B=7 -> stall_o high 33 cycles, then result 0x0007_0015, regwrite=1, single valid.
//  MUL mid-BUSY flush_i=1 -> EX/MEM bubble, stall_o=0 next cycle, next ADD executes normally.
//  mem_stall_i held 3 cycles in DONE -> EX/MEM frozen, product delivered once after release.
//  EX_OVF_TRAP_EN: ADD 0x7FFFFFFF+1 -> ovf_trap_o=1, exmem_regwrite_o=0; undefined -> 0x80000000, regwrite=1.
//  Async reset during BUSY -> all outputs 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - ALU opcodes, forwarding selects, multiplier states and control bundle for the EX stage
package ex_pkg;
  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;
  localparam logic [3:0] ALUOP_AND = 4'd2;
  localparam logic [3:0] ALUOP_OR  = 4'd3;
  localparam logic [3:0] ALUOP_XOR = 4'd4;
  localparam logic [3:0] ALUOP_NOR = 4'd5;
  localparam logic [3:0] ALUOP_SLT = 4'd6;
  localparam logic [3:0] ALUOP_SLL = 4'd7;
  localparam logic [3:0] ALUOP_SRL = 4'd8;
  localparam logic [3:0] ALUOP_SRA = 4'd9;
  localparam logic [3:0] ALUOP_LUI = 4'd10;
  localparam logic [3:0] ALUOP_MUL = 4'd11;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctl_t;
endpackage

// File: rtl/ex_stage_seq_multiplier.sv
// rtl/ex_stage_seq_multiplier.sv - shift-add multiplier, one partial product per cycle, DATA_W steps
module seq_multiplier
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              ack_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);
  localparam int CW = $clog2(DATA_W);

  mul_state_e        state_q;
  logic [DATA_W-1:0] a_q, b_q, acc_q;
  logic [CW-1:0]     cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= MUL_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (abort_i) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MUL_IDLE: if (start_i) begin
          a_q     <= a_i;
          b_q     <= b_i;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= MUL_BUSY;
        end
        MUL_BUSY: begin
          if (b_q[0]) acc_q <= acc_q + a_q;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) state_q <= MUL_DONE;
        end
        MUL_DONE: if (ack_i) state_q <= MUL_IDLE;
        default:  state_q <= MUL_IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q == MUL_BUSY);
  assign done_o    = (state_q == MUL_DONE);
  assign product_o = acc_q;
endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: operand forwarding, ALU, iterative MUL and the EX/MEM register
// Optional: EX_OVF_TRAP_EN turns signed ADD/SUB overflow into a bubble plus a one-cycle ovf_trap_o.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              idex_valid_i,
  input  logic [3:0]        idex_aluop_i,
  input  logic [DATA_W-1:0] idex_rs_data_i,
  input  logic [DATA_W-1:0] idex_rt_data_i,
  input  logic [DATA_W-1:0] idex_imm_i,
  input  logic              idex_alusrc_i,
  input  logic [4:0]        idex_shamt_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic              idex_regwrite_i,
  input  logic              idex_memread_i,
  input  logic              idex_memwrite_i,
  input  logic              idex_memtoreg_i,
  input  logic [1:0]        alu_data1_sel_i,
  input  logic [1:0]        alu_data2_sel_i,
  input  logic [DATA_W-1:0] exmem_fwd_data_i,
  input  logic [DATA_W-1:0] memwb_fwd_data_i,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              exmem_valid_o,
  output logic [DATA_W-1:0] exmem_alu_result_o,
  output logic [DATA_W-1:0] exmem_store_data_o,
  output logic [REG_AW-1:0] exmem_rd_o,
  output logic              exmem_regwrite_o,
  output logic              exmem_memread_o,
  output logic              exmem_memwrite_o,
  output logic              exmem_memtoreg_o,
  output logic              ovf_trap_o
);
  logic [DATA_W-1:0] op_a, st_data, op_b, alu_res, mul_prod;
  logic              is_mul, mul_busy, mul_done, mul_start_req, alu_ovf;
  ctl_t              ctl_in;

  always_comb begin
    case (alu_data1_sel_i)
      FWD_EXMEM:       op_a = exmem_fwd_data_i;
      FWD_MEMWB:       op_a = memwb_fwd_data_i;
      FWD_NONE, 2'b11: op_a = idex_rs_data_i;
    endcase
    case (alu_data2_sel_i)
      FWD_EXMEM:       st_data = exmem_fwd_data_i;
      FWD_MEMWB:       st_data = memwb_fwd_data_i;
      FWD_NONE, 2'b11: st_data = idex_rt_data_i;
    endcase
    op_b = idex_alusrc_i ? idex_imm_i : st_data;
  end

  always_comb begin
    alu_res = '0;
    case (idex_aluop_i)
      ALUOP_ADD: alu_res = op_a + op_b;
      ALUOP_SUB: alu_res = op_a - op_b;
      ALUOP_AND: alu_res = op_a & op_b;
      ALUOP_OR:  alu_res = op_a | op_b;
      ALUOP_XOR: alu_res = op_a ^ op_b;
      ALUOP_NOR: alu_res = ~(op_a | op_b);
      ALUOP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALUOP_SLL: alu_res = op_b << idex_shamt_i;
      ALUOP_SRL: alu_res = op_b >> idex_shamt_i;
      ALUOP_SRA: alu_res = $signed(op_b) >>> idex_shamt_i;
      ALUOP_LUI: alu_res = op_b << 16;
      default:   alu_res = '0;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  always_comb begin
    alu_ovf = 1'b0;
    if (idex_aluop_i == ALUOP_ADD)
      alu_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
    else if (idex_aluop_i == ALUOP_SUB)
      alu_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
  end
`else
  assign alu_ovf = 1'b0;
`endif

  assign is_mul        = idex_valid_i && (idex_aluop_i == ALUOP_MUL);
  assign mul_start_req = !mul_busy && !mul_done && is_mul && !flush_i;
  // Reset gating keeps stall_o low while rst_n_i is held, even with a MUL waiting in ID/EX.
  assign stall_o       = rst_n_i && (mem_stall_i || mul_start_req || mul_busy);
  assign ctl_in        = '{idex_regwrite_i, idex_memread_i, idex_memwrite_i, idex_memtoreg_i};

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (mul_start_req && !mem_stall_i),
    .abort_i   (flush_i),
    .ack_i     (mul_done && !mem_stall_i),
    .a_i       (op_a),
    .b_i       (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] res_d, res_q, st_d, st_q;
  logic [REG_AW-1:0] rd_d, rd_q;
  ctl_t              ctl_d, ctl_q;

  always_comb begin
    valid_d = 1'b0;
    res_d   = '0;
    st_d    = '0;
    rd_d    = '0;
    ctl_d   = '0;
    if (!flush_i && idex_valid_i && (mul_done || (!is_mul && !alu_ovf))) begin
      valid_d = 1'b1;
      res_d   = mul_done ? mul_prod : alu_res;
      st_d    = st_data;
      rd_d    = idex_rd_i;
      ctl_d   = ctl_in;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      st_q    <= '0;
      rd_q    <= '0;
      ctl_q   <= '0;
    end else if (flush_i || !mem_stall_i) begin
      valid_q <= valid_d;
      res_q   <= res_d;
      st_q    <= st_d;
      rd_q    <= rd_d;
      ctl_q   <= ctl_d;
    end
  end

`ifdef EX_OVF_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                     trap_q <= 1'b0;
    else if (flush_i || !mem_stall_i) trap_q <= !flush_i && idex_valid_i && !mul_done && !is_mul && alu_ovf;
  end
  assign ovf_trap_o = trap_q;
`else
  assign ovf_trap_o = 1'b0;
`endif

  assign exmem_valid_o      = valid_q;
  assign exmem_alu_result_o = res_q;
  assign exmem_store_data_o = st_q;
  assign exmem_rd_o         = rd_q;
  assign exmem_regwrite_o   = ctl_q.regwrite;
  assign exmem_memread_o    = ctl_q.memread;
  assign exmem_memwrite_o   = ctl_q.memwrite;
  assign exmem_memtoreg_o   = ctl_q.memtoreg;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - bench for ex_stage: directed forwarding/MUL/flush/stall/reset steps plus random ALU ops vs a reference model
module tb_ex_stage;
  import ex_pkg::*;

`ifdef EX_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic        idex_valid_i = 1'b0, idex_alusrc_i = 1'b0;
  logic [3:0]  idex_aluop_i = '0;
  logic [31:0] idex_rs_data_i = '0, idex_rt_data_i = '0, idex_imm_i = '0;
  logic [4:0]  idex_shamt_i = '0, idex_rd_i = '0;
  logic        idex_regwrite_i = 1'b0, idex_memread_i = 1'b0, idex_memwrite_i = 1'b0, idex_memtoreg_i = 1'b0;
  logic [1:0]  alu_data1_sel_i = 2'b11, alu_data2_sel_i = 2'b11;
  logic [31:0] exmem_fwd_data_i = '0, memwb_fwd_data_i = '0;
  logic        mem_stall_i = 1'b0, flush_i = 1'b0;
  logic        stall_o, exmem_valid_o, exmem_regwrite_o, exmem_memread_o, exmem_memwrite_o, exmem_memtoreg_o, ovf_trap_o;
  logic [31:0] exmem_alu_result_o, exmem_store_data_o;
  logic [4:0]  exmem_rd_o;

  int n_tests = 0, n_fail = 0;

  always #5 clk_i = ~clk_i;

  ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .idex_valid_i(idex_valid_i), .idex_aluop_i(idex_aluop_i),
    .idex_rs_data_i(idex_rs_data_i), .idex_rt_data_i(idex_rt_data_i), .idex_imm_i(idex_imm_i),
    .idex_alusrc_i(idex_alusrc_i), .idex_shamt_i(idex_shamt_i), .idex_rd_i(idex_rd_i),
    .idex_regwrite_i(idex_regwrite_i), .idex_memread_i(idex_memread_i), .idex_memwrite_i(idex_memwrite_i),
    .idex_memtoreg_i(idex_memtoreg_i), .alu_data1_sel_i(alu_data1_sel_i), .alu_data2_sel_i(alu_data2_sel_i),
    .exmem_fwd_data_i(exmem_fwd_data_i), .memwb_fwd_data_i(memwb_fwd_data_i), .mem_stall_i(mem_stall_i),
    .flush_i(flush_i), .stall_o(stall_o), .exmem_valid_o(exmem_valid_o), .exmem_alu_result_o(exmem_alu_result_o),
    .exmem_store_data_o(exmem_store_data_o), .exmem_rd_o(exmem_rd_o), .exmem_regwrite_o(exmem_regwrite_o),
    .exmem_memread_o(exmem_memread_o), .exmem_memwrite_o(exmem_memwrite_o), .exmem_memtoreg_o(exmem_memtoreg_o),
    .ovf_trap_o(ovf_trap_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] own, input logic [31:0] exf,
                                      input logic [31:0] mwf);
    if (sel == 2'b10) return exf;
    if (sel == 2'b01) return mwf;
    return own;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input int sh);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      ALUOP_ADD: return a + b;
      ALUOP_SUB: return a - b;
      ALUOP_AND: return a & b;
      ALUOP_OR:  return a | b;
      ALUOP_XOR: return a ^ b;
      ALUOP_NOR: return ~(a | b);
      ALUOP_SLT: return (sa < sb) ? 32'd1 : 32'd0;
      ALUOP_SLL: return b << sh;
      ALUOP_SRL: return b >> sh;
      ALUOP_SRA: return sb >>> sh;
      ALUOP_LUI: return {b[15:0], 16'h0000};
      ALUOP_MUL: return a * b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic bit signed_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (op == ALUOP_ADD)      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == ALUOP_SUB) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic set_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                        input logic alusrc, input logic [1:0] s1, input logic [1:0] s2,
                        input logic [31:0] exf, input logic [31:0] mwf);
    idex_valid_i = 1'b1; idex_aluop_i = op; idex_rs_data_i = rs; idex_rt_data_i = rt; idex_imm_i = imm;
    idex_alusrc_i = alusrc; alu_data1_sel_i = s1; alu_data2_sel_i = s2;
    exmem_fwd_data_i = exf; memwb_fwd_data_i = mwf;
    idex_regwrite_i = 1'b1; idex_memread_i = 1'b0; idex_memwrite_i = 1'b0; idex_memtoreg_i = 1'b0;
  endtask

  // Expected EX/MEM contents computed from the currently driven ID/EX, then one clock.
  task automatic run_single(input string tag);
    logic [31:0] a, st, b, r;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    bit          ov;
    a   = fwd(alu_data1_sel_i, idex_rs_data_i, exmem_fwd_data_i, memwb_fwd_data_i);
    st  = fwd(alu_data2_sel_i, idex_rt_data_i, exmem_fwd_data_i, memwb_fwd_data_i);
    b   = idex_alusrc_i ? idex_imm_i : st;
    r   = ref_alu(idex_aluop_i, a, b, int'(idex_shamt_i));
    ov  = TRAP_EN && signed_ovf(idex_aluop_i, a, b);
    ctl = {idex_regwrite_i, idex_memread_i, idex_memwrite_i, idex_memtoreg_i};
    rd  = idex_rd_i;
    tick();
    if (ov) begin
      check({tag, "_trap_valid"}, 64'(exmem_valid_o), 64'd0);
      check({tag, "_trap_result"}, 64'(exmem_alu_result_o), 64'd0);
      check({tag, "_trap_flag"}, 64'(ovf_trap_o), 64'd1);
    end else begin
      check({tag, "_valid"}, 64'(exmem_valid_o), 64'd1);
      check({tag, "_result"}, 64'(exmem_alu_result_o), 64'(r));
      check({tag, "_store"}, 64'(exmem_store_data_o), 64'(st));
      check({tag, "_rd"}, 64'(exmem_rd_o), 64'(rd));
      check({tag, "_ctl"}, 64'({exmem_regwrite_o, exmem_memread_o, exmem_memwrite_o, exmem_memtoreg_o}), 64'(ctl));
      check({tag, "_trap0"}, 64'(ovf_trap_o), 64'd0);
    end
  endtask

  // MUL is already driven in ID/EX; count stall cycles, then expect the product exactly once.
  task automatic run_mul(input string tag, input logic [31:0] exp);
    int cnt = 0;
    #1;
    while (stall_o === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    check({tag, "_stall_cycles"}, 64'(cnt), 64'd33);
    check({tag, "_bubble_before"}, 64'(exmem_valid_o), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(exmem_valid_o), 64'd1);
    check({tag, "_product"}, 64'(exmem_alu_result_o), 64'(exp));
    check({tag, "_regwrite"}, 64'(exmem_regwrite_o), 64'd1);
    idex_valid_i = 1'b0;
    tick();
    check({tag, "_single"}, 64'(exmem_valid_o), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          cnt;

    #2;
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_valid", 64'(exmem_valid_o), 64'd0);
    check("rst_result", 64'(exmem_alu_result_o), 64'd0);
    check("rst_trap", 64'(ovf_trap_o), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();

    idex_rd_i = 5'd3;
    set_op(ALUOP_ADD, 32'd9, 32'd0, 32'd3, 1'b1, 2'b10, 2'b11, 32'd5, 32'd0);
    run_single("fwd_exmem");
    check("fwd_exmem_const", 64'(exmem_alu_result_o), 64'd8);
    set_op(ALUOP_ADD, 32'd9, 32'd0, 32'd3, 1'b1, 2'b01, 2'b11, 32'd5, 32'd7);
    run_single("fwd_memwb");
    check("fwd_memwb_const", 64'(exmem_alu_result_o), 64'd10);
    set_op(ALUOP_SUB, 32'd1, 32'd2, 32'd0, 1'b0, 2'b10, 2'b01, 32'd20, 32'd3);
    run_single("fwd_both");
    check("fwd_both_const", 64'(exmem_alu_result_o), 64'd17);
    set_op(ALUOP_SUB, 32'd4, 32'd6, 32'd0, 1'b0, 2'b11, 2'b11, 32'd99, 32'd98);
    run_single("nofwd_sub");
    check("nofwd_sub_const", 64'(exmem_alu_result_o), 64'hFFFF_FFFE);

    set_op(ALUOP_ADD, 32'h7FFF_FFFF, 32'd0, 32'd1, 1'b1, 2'b11, 2'b11, 32'd0, 32'd0);
    run_single("ovf_add");
    if (TRAP_EN) check("ovf_regwrite", 64'(exmem_regwrite_o), 64'd0);
    else         check("ovf_wrap", 64'(exmem_alu_result_o), 64'h8000_0000);

    for (int i = 0; i < 40; i++) begin
      set_op(4'($urandom_range(0, 10)), $urandom, $urandom, $urandom, 1'($urandom), 2'($urandom), 2'($urandom),
             $urandom, $urandom);
      if (i % 4 == 0) idex_rs_data_i = 32'h8000_0000 | 32'($urandom_range(0, 3));
      idex_shamt_i = 5'($urandom);
      idex_rd_i = 5'($urandom);
      {idex_regwrite_i, idex_memread_i, idex_memwrite_i, idex_memtoreg_i} = 4'($urandom);
      run_single($sformatf("rand%0d", i));
    end
    idex_rd_i = 5'd4;

    set_op(ALUOP_MUL, 32'h0001_0003, 32'd7, 32'd0, 1'b0, 2'b11, 2'b11, 32'd0, 32'd0);
    run_mul("mul_dir", 32'h0007_0015);
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      set_op(ALUOP_MUL, 32'd0, rb, 32'd0, 1'b0, 2'b10, 2'b11, ra, 32'd0);
      run_mul($sformatf("mul_rand%0d", i), ref_alu(ALUOP_MUL, ra, rb, 0));
    end

    set_op(ALUOP_MUL, 32'd5, 32'd6, 32'd0, 1'b0, 2'b11, 2'b11, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_bubble", 64'(exmem_valid_o), 64'd0);
    set_op(ALUOP_ADD, 32'd100, 32'd23, 32'd0, 1'b0, 2'b11, 2'b11, 32'd0, 32'd0);
    #1;
    check("flush_stall_low", 64'(stall_o), 64'd0);
    run_single("flush_next_add");

    set_op(ALUOP_MUL, 32'd1234, 32'd567, 32'd0, 1'b0, 2'b11, 2'b11, 32'd0, 32'd0);
    #1;
    cnt = 0;
    while (stall_o === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    check("mstall_cycles", 64'(cnt), 64'd33);
    mem_stall_i = 1'b1;
    #1;
    check("mstall_stall_hi", 64'(stall_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mstall_frozen%0d", i), 64'({exmem_valid_o, exmem_alu_result_o}), 64'd0);
    end
    mem_stall_i = 1'b0;
    tick();
    check("mstall_valid", 64'(exmem_valid_o), 64'd1);
    check("mstall_product", 64'(exmem_alu_result_o), 64'd699678);
    idex_valid_i = 1'b0;
    tick();
    check("mstall_once", 64'(exmem_valid_o), 64'd0);

    set_op(ALUOP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 2'b11, 2'b11, 32'd0, 32'd0);
    tick();
    set_op(ALUOP_MUL, 32'd3, 32'd4, 32'd0, 1'b0, 2'b11, 2'b11, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_stall", 64'(stall_o), 64'd0);
    check("arst_valid", 64'(exmem_valid_o), 64'd0);
    check("arst_result", 64'(exmem_alu_result_o), 64'd0);
    check("arst_regwrite", 64'(exmem_regwrite_o), 64'd0);
    idex_valid_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    check("arst_idle_stall", 64'(stall_o), 64'd0);
    set_op(ALUOP_OR, 32'hF0, 32'h0F, 32'd0, 1'b0, 2'b11, 2'b11, 32'd0, 32'd0);
    run_single("arst_next_or");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
